// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared registered ALU.
// Each requester issues one operation at a time and receives the result with flags.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_ctrl,
    input  logic [4:0]        req0_shamt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_ctrl,
    input  logic [4:0]        req1_shamt,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_less,
    output logic              rsp0_overflow,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_less,
    output logic              rsp1_overflow,
    output logic [DATA_W-1:0] alu_operand_A,
    output logic [DATA_W-1:0] alu_operand_B,
    output logic [3:0]        alu_control,
    output logic [4:0]        alu_shmant,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_less,
    input  logic              alu_overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
    state_t state;
    logic   owner;
    logic   last_grant;
    logic   idle;
    logic   rsp_hs;
    assign idle = reset && state == IDLE;
    // On a tie the requester that did not complete last wins.
    assign req0_ready = idle && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
    assign rsp_hs = owner ? rsp1_valid && rsp1_ready : rsp0_valid && rsp0_ready;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            ops_done      <= '0;
            alu_operand_A <= '0;
            alu_operand_B <= '0;
            alu_control   <= '0;
            alu_shmant    <= '0;
            rsp0_valid    <= 1'b0;
            rsp0_result   <= '0;
            rsp0_zero     <= 1'b0;
            rsp0_less     <= 1'b0;
            rsp0_overflow <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp1_result   <= '0;
            rsp1_zero     <= 1'b0;
            rsp1_less     <= 1'b0;
            rsp1_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    owner         <= req1_ready;
                    alu_operand_A <= req1_ready ? req1_a : req0_a;
                    alu_operand_B <= req1_ready ? req1_b : req0_b;
                    alu_control   <= req1_ready ? req1_ctrl : req0_ctrl;
                    alu_shmant    <= req1_ready ? req1_shamt : req0_shamt;
                    state         <= EXEC;
                end
                EXEC: state <= CAPT;
                CAPT: begin
                    if (owner) begin
                        rsp1_valid    <= 1'b1;
                        rsp1_result   <= alu_result;
                        rsp1_zero     <= alu_zero;
                        rsp1_less     <= alu_less;
                        rsp1_overflow <= alu_overflow;
                    end else begin
                        rsp0_valid    <= 1'b1;
                        rsp0_result   <= alu_result;
                        rsp0_zero     <= alu_zero;
                        rsp0_less     <= alu_less;
                        rsp0_overflow <= alu_overflow;
                    end
                    state <= RESP;
                end
                RESP: if (rsp_hs) begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    last_grant <= owner;
                    ops_done   <= ops_done + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
